// File: rtl/lcd_cmd_dispatcher.sv
// Command front-end for LCD_CTRL: buffers host opcodes in a FIFO, drops illegal ones,
// and issues legal ones as single-cycle strobes that respect busy and the WRITE/done handshake.
module lcd_cmd_dispatcher #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    host_cmd,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          busy,
   input  logic          done,
   output logic [3:0]    cmd,
   output logic          cmd_valid,
   output logic [AW:0]   fifo_level,
   output logic          frame_done,
   output logic [7:0]    issued_cnt,
   output logic [7:0]    drop_cnt,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_GUARD     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   localparam logic [AW:0] C_FULL       = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_LVL_ONE    = (AW+1)'(1);
   localparam logic [AW:0] C_LVL_ZERO   = '0;
   localparam logic [3:0]  C_OP_WRITE   = 4'd0;
   localparam logic [3:0]  C_LAST_LEGAL = 4'd11;
   localparam logic [7:0]  C_CNT_MAX    = 8'hFF;

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   state_t        r_state;
   logic [3:0]    r_cmd;
   logic          r_cmd_valid;
   logic          r_done_q;
   logic          r_frame_done;
   logic [7:0]    r_issued_cnt;
   logic [7:0]    r_drop_cnt;

   state_t        w_state_nxt;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic          w_drop;
   logic [3:0]    w_head;
   logic          w_head_legal;
   logic          w_done_rise;
   logic          w_last_entry;
   logic [AW:0]   w_level_nxt;

   // Host handshake: an entry transfers on every rising edge where host_valid and
   // host_ready are both high; host_ready depends only on the registered level.
   assign host_ready   = (r_level != C_FULL);
   assign w_push       = host_valid & host_ready;
   assign w_head       = r_mem[r_rptr];
   assign w_head_legal = (w_head <= C_LAST_LEGAL);
   assign w_done_rise  = done & ~r_done_q;
   // A pop of the only entry empties the FIFO unless a push lands in the same cycle.
   assign w_last_entry = (r_level == C_LVL_ONE) & ~w_push;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + C_LVL_ONE;
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - C_LVL_ONE;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_issue     = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_level != C_LVL_ZERO) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (r_level == C_LVL_ZERO) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_head_legal) begin
               w_pop  = 1'b1;
               w_drop = 1'b1;
               if (w_last_entry) begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (!busy) begin
               w_pop       = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = (w_head == C_OP_WRITE) ? ST_WAIT_DONE : ST_GUARD;
            end
         end
         ST_GUARD: begin
            w_state_nxt = (r_level != C_LVL_ZERO) ? ST_ISSUE : ST_IDLE;
         end
         ST_WAIT_DONE: begin
            if (w_done_rise) begin
               w_state_nxt = (r_level != C_LVL_ZERO) ? ST_ISSUE : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Storage needs no reset: the pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= host_cmd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_state <= ST_IDLE;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_level <= w_level_nxt;
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd        <= '0;
         r_cmd_valid  <= 1'b0;
         r_done_q     <= 1'b0;
         r_frame_done <= 1'b0;
         r_issued_cnt <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_cmd_valid  <= w_issue;
         r_done_q     <= done;
         r_frame_done <= w_done_rise;
         if (w_issue) begin
            r_cmd <= w_head;
         end
         if (w_issue && (r_issued_cnt != C_CNT_MAX)) begin
            r_issued_cnt <= r_issued_cnt + 8'd1;
         end
         if (w_drop && (r_drop_cnt != C_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign cmd        = r_cmd;
   assign cmd_valid  = r_cmd_valid;
   assign fifo_level = r_level;
   assign frame_done = r_frame_done;
   assign issued_cnt = r_issued_cnt;
   assign drop_cnt   = r_drop_cnt;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_cmd_dispatcher.sv
// Bench for lcd_cmd_dispatcher: directed scenarios plus a randomized run, all strobes
// checked against a queue of expected legal opcodes and the issue/done/busy rules.
module tb_lcd_cmd_dispatcher;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    host_cmd = '0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          busy = 1'b0;
   logic          done = 1'b0;
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [AW:0]   fifo_level;
   logic          frame_done;
   logic [7:0]    issued_cnt;
   logic [7:0]    drop_cnt;
   logic [1:0]    dbg_state;

   lcd_cmd_dispatcher #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .host_cmd   (host_cmd),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .busy       (busy),
      .done       (done),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .fifo_level (fifo_level),
      .frame_done (frame_done),
      .issued_cnt (issued_cnt),
      .drop_cnt   (drop_cnt),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];
   int         strobe_cyc_q[$];
   int         fd_cyc_q[$];
   int         m_issued = 0;
   int         m_drop = 0;
   bit         m_wait = 1'b0;
   int         last_strobe = -100;
   logic       d1 = 1'b0;
   logic       d2 = 1'b0;
   logic       busy_seen = 1'b0;

   // Reference model: every legal opcode accepted is issued once, in order; illegal ones only count.
   task automatic model_accept(input logic [3:0] op);
      if (op <= 4'd11) begin
         exp_q.push_back(op);
         if (m_issued < 255) m_issued++;
      end else begin
         if (m_drop < 255) m_drop++;
      end
   endtask

   task automatic monitor();
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            d1 = 1'b0; d2 = 1'b0; busy_seen = 1'b0; m_wait = 1'b0; last_strobe = -100;
            continue;
         end
         n_checks++;
         if (frame_done !== (d1 & ~d2)) begin
            n_errors++;
            $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, d1 & ~d2);
         end
         if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
         if (cmd_valid === 1'b1) begin
            strobe_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL strobe_unexpected cyc=%0d got cmd=%0d exp=no strobe", cyc, cmd);
            end else begin
               e = exp_q.pop_front();
               if (cmd !== e) begin
                  n_errors++;
                  $display("FAIL strobe_order cyc=%0d got cmd=%0d exp=%0d", cyc, cmd, e);
               end
            end
            n_checks++;
            if (m_wait) begin
               n_errors++;
               $display("FAIL write_block cyc=%0d got strobe cmd=%0d exp=none before done", cyc, cmd);
            end
            n_checks++;
            if (busy_seen) begin
               n_errors++;
               $display("FAIL busy_honour cyc=%0d got strobe exp=none while busy", cyc);
            end
            n_checks++;
            if (cyc - last_strobe < 2) begin
               n_errors++;
               $display("FAIL strobe_spacing cyc=%0d got gap=%0d exp>=2", cyc, cyc - last_strobe);
            end
            last_strobe = cyc;
            if (cmd == 4'd0) m_wait = 1'b1;
         end
         if (done && !d1) m_wait = 1'b0;
         d2 = d1;
         d1 = done;
         busy_seen = busy;
      end
   endtask

   task automatic reset_dut();
      reset = 1'b0;
      host_valid = 1'b0;
      host_cmd = '0;
      busy = 1'b0;
      done = 1'b0;
      exp_q.delete();
      strobe_cyc_q.delete();
      fd_cyc_q.delete();
      m_issued = 0;
      m_drop = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic push_one(input logic [3:0] op, output bit acc);
      host_cmd = op;
      host_valid = 1'b1;
      acc = host_ready;
      @(posedge clk);
      #1 host_valid = 1'b0;
      if (acc) model_accept(op);
   endtask

   task automatic push_wait(input logic [3:0] op);
      bit acc;
      int t;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 64) begin
         push_one(op, acc);
         t++;
      end
      n_checks++;
      if (!acc) begin
         n_errors++;
         $display("FAIL push_timeout got=refused exp=accepted op=%0d", op);
      end
   endtask

   task automatic wait_quiet(input int bound);
      int q;
      int t;
      q = 0;
      t = 0;
      while (q < 4 && t < bound) begin
         @(posedge clk);
         #1;
         if (fifo_level == 0 && cmd_valid == 1'b0) q++;
         else q = 0;
         t++;
      end
      n_checks++;
      if (q < 4) begin
         n_errors++;
         $display("FAIL quiet_timeout got level=%0d exp=0 within %0d cycles", fifo_level, bound);
      end
   endtask

   task automatic check_counts(input string name);
      n_checks++;
      if (issued_cnt !== 8'(m_issued)) begin
         n_errors++;
         $display("FAIL %s_issued got=%0d exp=%0d", name, issued_cnt, m_issued);
      end
      n_checks++;
      if (drop_cnt !== 8'(m_drop)) begin
         n_errors++;
         $display("FAIL %s_drop got=%0d exp=%0d", name, drop_cnt, m_drop);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_pending got=%0d unissued exp=0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      bit acc;
      reset = 1'b0;
      host_valid = 1'b1;
      host_cmd = 4'd5;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (cmd !== 4'd0 || cmd_valid !== 1'b0 || frame_done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got cmd=%0d cv=%b fd=%b exp=0/0/0", cmd, cmd_valid, frame_done);
      end
      n_checks++;
      if (host_ready !== 1'b1 || fifo_level !== '0) begin
         n_errors++;
         $display("FAIL reset_fifo got ready=%b level=%0d exp=1/0", host_ready, fifo_level);
      end
      n_checks++;
      if (issued_cnt !== 8'd0 || drop_cnt !== 8'd0 || dbg_state !== 2'd0) begin
         n_errors++;
         $display("FAIL reset_counts got iss=%0d drop=%0d st=%0d exp=0/0/0", issued_cnt, drop_cnt, dbg_state);
      end
      host_valid = 1'b0;
      exp_q.delete();
      strobe_cyc_q.delete();
      fd_cyc_q.delete();
      m_issued = 0;
      m_drop = 0;
      reset = 1'b1;
      push_one(4'd3, acc);
      n_checks++;
      if (fifo_level !== 5'd1) begin
         n_errors++;
         $display("FAIL reset_first_push got level=%0d exp=1", fifo_level);
      end
      wait_quiet(50);
      check_counts("reset");
   endtask

   task automatic test_basic();
      bit acc;
      int p0;
      reset_dut();
      push_one(4'd1, acc);
      p0 = cyc;
      push_one(4'd3, acc);
      push_one(4'd5, acc);
      wait_quiet(50);
      n_checks++;
      if (strobe_cyc_q.size() != 3) begin
         n_errors++;
         $display("FAIL basic_count got=%0d exp=3", strobe_cyc_q.size());
      end else begin
         n_checks++;
         if (strobe_cyc_q[0] != p0 + 2) begin
            n_errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", strobe_cyc_q[0] - p0, 2);
         end
         n_checks++;
         if (strobe_cyc_q[1] - strobe_cyc_q[0] != 2 || strobe_cyc_q[2] - strobe_cyc_q[1] != 2) begin
            n_errors++;
            $display("FAIL basic_gap got=%0d,%0d exp=2,2", strobe_cyc_q[1] - strobe_cyc_q[0],
                     strobe_cyc_q[2] - strobe_cyc_q[1]);
         end
      end
      check_counts("basic");
   endtask

   task automatic test_busy_stall();
      bit acc;
      reset_dut();
      busy = 1'b1;
      for (int i = 0; i < 4; i++) push_one(4'($urandom_range(1, 11)), acc);
      repeat (16) @(posedge clk);
      #1;
      n_checks++;
      if (strobe_cyc_q.size() != 0 || fifo_level !== 5'd4) begin
         n_errors++;
         $display("FAIL stall_hold got strobes=%0d level=%0d exp=0/4", strobe_cyc_q.size(), fifo_level);
      end
      busy = 1'b0;
      wait_quiet(50);
      n_checks++;
      if (strobe_cyc_q.size() != 4) begin
         n_errors++;
         $display("FAIL stall_release got=%0d exp=4", strobe_cyc_q.size());
      end
      check_counts("stall");
   endtask

   task automatic test_illegal();
      bit acc;
      reset_dut();
      push_one(4'd12, acc);
      push_one(4'd2, acc);
      push_one(4'd15, acc);
      wait_quiet(50);
      n_checks++;
      if (strobe_cyc_q.size() != 1 || drop_cnt !== 8'd2 || issued_cnt !== 8'd1) begin
         n_errors++;
         $display("FAIL illegal_result got strobes=%0d drop=%0d iss=%0d exp=1/2/1",
                  strobe_cyc_q.size(), drop_cnt, issued_cnt);
      end
      check_counts("illegal");
   endtask

   task automatic test_write();
      bit acc;
      int t;
      int dcyc;
      reset_dut();
      push_one(4'd0, acc);
      push_one(4'd4, acc);
      t = 0;
      while (strobe_cyc_q.size() == 0 && t < 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (strobe_cyc_q.size() != 1) begin
         n_errors++;
         $display("FAIL write_wait got strobes=%0d exp=1", strobe_cyc_q.size());
      end
      done = 1'b1;
      dcyc = cyc;
      repeat (3) @(posedge clk);
      #1 done = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (fd_cyc_q.size() != 1) begin
         n_errors++;
         $display("FAIL write_frame_done got pulses=%0d exp=1", fd_cyc_q.size());
      end else begin
         n_checks++;
         if (fd_cyc_q[0] != dcyc + 1) begin
            n_errors++;
            $display("FAIL write_fd_time got=%0d exp=%0d", fd_cyc_q[0] - dcyc, 1);
         end
      end
      n_checks++;
      if (strobe_cyc_q.size() != 2) begin
         n_errors++;
         $display("FAIL write_resume got strobes=%0d exp=2", strobe_cyc_q.size());
      end else begin
         n_checks++;
         if (strobe_cyc_q[1] != dcyc + 2) begin
            n_errors++;
            $display("FAIL write_resume_time got=%0d exp=%0d", strobe_cyc_q[1] - dcyc, 2);
         end
      end
      wait_quiet(50);
      check_counts("write");
   endtask

   task automatic test_done_idle();
      reset_dut();
      repeat (2) @(posedge clk);
      #1 done = 1'b1;
      repeat (4) @(posedge clk);
      #1 done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (fd_cyc_q.size() != 1 || strobe_cyc_q.size() != 0 || fifo_level !== '0) begin
         n_errors++;
         $display("FAIL done_idle got pulses=%0d strobes=%0d level=%0d exp=1/0/0",
                  fd_cyc_q.size(), strobe_cyc_q.size(), fifo_level);
      end
      check_counts("done_idle");
   endtask

   task automatic test_full_reset();
      bit acc;
      int n_acc;
      int t;
      reset_dut();
      busy = 1'b1;
      n_acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         push_one(4'($urandom_range(1, 11)), acc);
         if (acc) n_acc++;
      end
      n_checks++;
      if (n_acc != DEPTH || host_ready !== 1'b0 || fifo_level !== 5'(DEPTH)) begin
         n_errors++;
         $display("FAIL full_state got acc=%0d ready=%b level=%0d exp=%0d/0/%0d",
                  n_acc, host_ready, fifo_level, DEPTH, DEPTH);
      end
      busy = 1'b0;
      t = 0;
      while (cmd_valid !== 1'b1 && t < 10) begin
         @(posedge clk);
         #1;
         t++;
      end
      n_checks++;
      if (cmd_valid !== 1'b1 || host_ready !== 1'b1 || fifo_level !== 5'(DEPTH - 1)) begin
         n_errors++;
         $display("FAIL full_pop got cv=%b ready=%b level=%0d exp=1/1/%0d",
                  cmd_valid, host_ready, fifo_level, DEPTH - 1);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (fifo_level !== '0 || cmd_valid !== 1'b0 || host_ready !== 1'b1 || issued_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL async_reset got level=%0d cv=%b ready=%b iss=%0d exp=0/0/1/0",
                  fifo_level, cmd_valid, host_ready, issued_cnt);
      end
      reset_dut();
      wait_quiet(20);
      check_counts("full");
   endtask

   task automatic test_saturate();
      reset_dut();
      for (int i = 0; i < 260; i++) push_wait(4'(12 + $urandom_range(0, 3)));
      wait_quiet(100);
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_errors++;
         $display("FAIL drop_saturate got=%0d exp=255", drop_cnt);
      end
      for (int i = 0; i < 260; i++) push_wait(4'($urandom_range(1, 11)));
      wait_quiet(100);
      n_checks++;
      if (issued_cnt !== 8'd255) begin
         n_errors++;
         $display("FAIL issued_saturate got=%0d exp=255", issued_cnt);
      end
      check_counts("saturate");
   endtask

   task automatic test_random();
      bit acc;
      int dhold;
      int q;
      int t;
      logic [3:0] op;
      reset_dut();
      dhold = 0;
      repeat (600) begin
         busy = ($urandom_range(0, 3) == 0);
         if (dhold > 0) begin
            dhold--;
            if (dhold == 0) done = 1'b0;
         end else if (!done && ((m_wait && $urandom_range(0, 3) == 0) || $urandom_range(0, 29) == 0)) begin
            done = 1'b1;
            dhold = $urandom_range(1, 3);
         end
         if ($urandom_range(0, 2) != 0) begin
            op = ($urandom_range(0, 4) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
            push_one(op, acc);
         end else begin
            @(posedge clk);
            #1;
         end
      end
      busy = 1'b0;
      q = 0;
      t = 0;
      while (q < 4 && t < 400) begin
         @(posedge clk);
         #1;
         if (done) done = 1'b0;
         else if (m_wait) done = 1'b1;
         if (fifo_level == 0 && cmd_valid == 1'b0 && !m_wait && !done) q++;
         else q = 0;
         t++;
      end
      n_checks++;
      if (q < 4) begin
         n_errors++;
         $display("FAIL random_drain got level=%0d exp=0 within 400 cycles", fifo_level);
      end
      check_counts("random");
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_busy_stall();
      test_illegal();
      test_write();
      test_done_idle();
      test_full_reset();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/lcd_cmd_dispatcher.md
# lcd_cmd_dispatcher

Command front-end for `LCD_CTRL`; it sits directly upstream of `LCD_CTRL`'s `cmd`/`cmd_valid`/`busy` port.
- Buffers 4-bit opcodes from a host in a FIFO.
- Drops illegal opcodes.
- Issues each legal opcode to `LCD_CTRL` as a single-cycle `cmd_valid` pulse, honouring `busy`.
- Blocks after a WRITE (opcode 0) until `LCD_CTRL` reports `done`.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, ≥2.
- `AW`, 4: log2(`DEPTH`).
- `clk`  in  1: clock. All state changes on rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `host_cmd`  in  4: opcode from host.
- `host_valid`  in  1: `host_cmd` valid. Pushed on a cycle where `host_valid & host_ready`.
- `host_ready`  out  1: FIFO not full.
- `busy`  in  1: from `LCD_CTRL`. High means it accepts no command.
- `done`  in  1: from `LCD_CTRL`. High after WRITE completes.
- `cmd`  out  4: opcode to `LCD_CTRL`. Registered.
- `cmd_valid`  out  1: single-cycle issue strobe. Registered.
- `fifo_level`  out  AW+1: entries currently held, 0..`DEPTH`.
- `frame_done`  out  1: one-cycle pulse on the rising edge of `done`.
- `issued_cnt`  out  8: legal opcodes issued. Saturates at 255.
- `drop_cnt`  out  8: illegal opcodes discarded. Saturates at 255.

## Operation
- Legal opcodes are 0..11:
  - 0 WRITE
  - 1–4 shift up/down/left/right
  - 5 MAX, 6 MIN, 7 AVERAGE
  - 8 CCW rotate, 9 CW rotate
  - 10 mirror X, 11 mirror Y
- Opcodes 12..15 are illegal. They are accepted into the FIFO and discarded at the head.
- FIFO:
  - Circular buffer with AW-bit read/write pointers that wrap at `DEPTH`.
  - `host_ready = (fifo_level != DEPTH)`.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - No fall-through: a pushed entry is visible at the head the following cycle.
- States:
  - IDLE: FIFO empty. Go to ISSUE when `fifo_level != 0`.
  - ISSUE, head illegal: pop, increment `drop_cnt`, no strobe. Stay in ISSUE, or go to IDLE if that pop empties the FIFO.
  - ISSUE, head legal and `busy` low: pop, drive `cmd` = head, pulse `cmd_valid`, increment `issued_cnt`. Next state is WAIT_DONE if opcode = 0, else GUARD.
  - ISSUE, head legal and `busy` high: hold. No pop, no strobe.
  - GUARD: exactly one cycle with `cmd_valid` low. This lets `LCD_CTRL` raise `busy`. Then go to ISSUE if the FIFO is non-empty, else IDLE.
  - WAIT_DONE: no issues; the host may keep pushing. On the `done` rising edge, pulse `frame_done` and go to ISSUE/IDLE as in GUARD.
- `frame_done`:
  - Computed from a registered copy of `done`: `done & ~done_q`, registered.
  - Pulses in any state.
  - A `done` held high gives one pulse.
- `cmd` holds its last issued value between strobes.
- Counters saturate at 255 and never wrap.
- Reset mid-operation: all state clears immediately and asynchronously.
  - FIFO contents are lost.
  - A `cmd_valid` in progress is cut short.

## Timing
- Reset values:
  - `cmd` = 0, `cmd_valid` = 0, `frame_done` = 0.
  - `host_ready` = 1, `fifo_level` = 0.
  - `issued_cnt` = 0, `drop_cnt` = 0.
  - State = IDLE, pointers = 0, `done_q` = 0.
- Latency: host push at edge N, FIFO previously empty, `busy` low → `cmd_valid` high for the cycle after edge N+2. The path is IDLE → ISSUE (N+1), then the issue registers at N+2.
- Minimum spacing between strobes is 2 cycles (ISSUE, GUARD), even with `busy` stuck low.
- `busy` is sampled in ISSUE only. `busy` rising in the same cycle the strobe registers does not cancel the issue.
- `done` rising while not in WAIT_DONE gives a `frame_done` pulse with no state change.
- Full FIFO plus `host_valid`: the push is refused, and `fifo_level` stays at `DEPTH` unless a pop occurs that cycle. A pop while full raises `host_ready` the next cycle.
- `fifo_level` updates one cycle after the push/pop edge.

## Test plan
- Reset: hold `reset` low with a running clock → all outputs at reset values. Release, push 3 → `fifo_level` = 1 one cycle after the push.
- Basic issue: push 1, 3, 5 with `busy` low → three `cmd_valid` pulses with `cmd` = 1, 3, 5, 2 cycles apart. `issued_cnt` = 3, `fifo_level` back to 0.
- Busy stall: hold `busy` high for 20 cycles while pushing 4 opcodes → no strobe. After release, all 4 issue in order and none is lost or duplicated.
- Illegal opcodes: push 12, 2, 15 → only `cmd` = 2 is issued; `drop_cnt` = 2, `issued_cnt` = 1.
- WRITE block: push 0, 4; pulse `done` 10 cycles later →
  - `cmd` = 0 issued, then nothing during those 10 cycles.
  - `frame_done` pulses once.
  - `cmd` = 4 issues 2 cycles after `done` rises.
- Full FIFO and reset: hold `busy` high, push `DEPTH`+2 opcodes → `host_ready` goes low after `DEPTH` accepts and `fifo_level` = `DEPTH`. Assert `reset` mid-stream → `fifo_level` = 0 and `cmd_valid` = 0 immediately, with no clock edge needed.
